// File: rtl/nco_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel NCO.
package nco_pkg;

  localparam logic SEL_INC = 1'b0;
  localparam logic SEL_OFF = 1'b1;

  localparam real PI = 3.14159265358979323846;

  function automatic int lut_depth(input int lut_aw);
    return 1 << lut_aw;
  endfunction

  function automatic int lut_amp(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // Select width for a channel count, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/quarter_sine_lut.sv
// Quarter-wave sine magnitude ROM with one registered read port.
// Entries are sampled at half-index midpoints so the fold is exact.
module quarter_sine_lut
  import nco_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  data_o
);

  localparam int DEPTH = lut_depth(LUT_AW);
  localparam int AMP   = lut_amp(OUT_W);

  logic [OUT_W-2:0] rom [DEPTH];
  logic [OUT_W-2:0] data_q, data_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real ANGLE = 2.0 * PI * (real'(k) + 0.5) / real'(4 * DEPTH);
    localparam int  VAL   = $rtoi(real'(AMP) * $sin(ANGLE) + 0.5);
    assign rom[k] = (OUT_W-1)'(VAL);
  end

  always_comb begin
    data_d = data_q;
    if (en) data_d = rom[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/nco_multi_ch.sv
// Multi-channel quadrature NCO: shadowed config, phase accumulators and a
// five-stage fold/LUT/sign pipeline that advances only on clken.
module nco_multi_ch
  import nco_pkg::*;
#(
  parameter  int N_CH   = 2,
  parameter  int ACC_W  = 32,
  parameter  int LUT_AW = 10,
  parameter  int OUT_W  = 14,
  localparam int CH_W   = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic                  cfg_sel,
  input  logic [ACC_W-1:0]      cfg_data,
  input  logic                  apply,
  input  logic                  clr,
  output logic [N_CH*OUT_W-1:0] fsin_o,
  output logic [N_CH*OUT_W-1:0] fcos_o,
  output logic                  out_valid
);

  localparam int PH_W  = LUT_AW + 2;
  localparam int MAG_W = OUT_W - 1;

  logic [ACC_W-1:0]  inc_sh_q  [N_CH], inc_sh_d  [N_CH];
  logic [ACC_W-1:0]  off_sh_q  [N_CH], off_sh_d  [N_CH];
  logic [ACC_W-1:0]  inc_act_q [N_CH], inc_act_d [N_CH];
  logic [ACC_W-1:0]  off_act_q [N_CH], off_act_d [N_CH];
  logic [ACC_W-1:0]  acc_q     [N_CH], acc_d     [N_CH];
  logic [PH_W-1:0]   phase_q   [N_CH], phase_d   [N_CH];
  logic [LUT_AW-1:0] sin_addr_q[N_CH], sin_addr_d[N_CH];
  logic [LUT_AW-1:0] cos_addr_q[N_CH], cos_addr_d[N_CH];
  logic [N_CH-1:0]   sin_neg2_q, sin_neg2_d, cos_neg2_q, cos_neg2_d;
  logic [N_CH-1:0]   sin_neg3_q, sin_neg3_d, cos_neg3_q, cos_neg3_d;
  logic [OUT_W-1:0]  sin_q     [N_CH], sin_d     [N_CH];
  logic [OUT_W-1:0]  cos_q     [N_CH], cos_d     [N_CH];
  logic [1:0]        fill_q, fill_d;
  logic              valid_q, valid_d;

  logic [1:0]        quad_s [N_CH], quad_c [N_CH];
  logic [LUT_AW-1:0] idx    [N_CH];
  logic [MAG_W-1:0]  sin_mag[N_CH], cos_mag[N_CH];

  function automatic logic [PH_W-1:0] trunc_phase(input logic [ACC_W-1:0] acc,
                                                  input logic [ACC_W-1:0] off);
    return PH_W'((acc + off) >> (ACC_W - PH_W));
  endfunction

  // Odd quadrants run the quarter wave backwards.
  function automatic logic [LUT_AW-1:0] fold(input logic [1:0] quad,
                                             input logic [LUT_AW-1:0] ix);
    return quad[0] ? ~ix : ix;
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign quad_s[g] = phase_q[g][PH_W-1 -: 2];
    assign quad_c[g] = quad_s[g] + 2'd1;
    assign idx[g]    = phase_q[g][LUT_AW-1:0];

    quarter_sine_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_sin_lut (
      .clk(clk), .reset_n(reset_n), .en(clken),
      .addr(sin_addr_q[g]), .data_o(sin_mag[g])
    );
    quarter_sine_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_cos_lut (
      .clk(clk), .reset_n(reset_n), .en(clken),
      .addr(cos_addr_q[g]), .data_o(cos_mag[g])
    );
  end

  always_comb begin
    fill_d     = fill_q;
    valid_d    = valid_q;
    sin_neg2_d = sin_neg2_q;
    cos_neg2_d = cos_neg2_q;
    sin_neg3_d = sin_neg3_q;
    cos_neg3_d = cos_neg3_q;
    for (int c = 0; c < N_CH; c++) begin
      inc_sh_d[c]   = inc_sh_q[c];
      off_sh_d[c]   = off_sh_q[c];
      inc_act_d[c]  = inc_act_q[c];
      off_act_d[c]  = off_act_q[c];
      acc_d[c]      = acc_q[c];
      phase_d[c]    = phase_q[c];
      sin_addr_d[c] = sin_addr_q[c];
      cos_addr_d[c] = cos_addr_q[c];
      sin_d[c]      = sin_q[c];
      cos_d[c]      = cos_q[c];

      if (cfg_we && (int'(cfg_ch) == c)) begin
        if (cfg_sel == SEL_OFF) off_sh_d[c] = cfg_data;
        else                    inc_sh_d[c] = cfg_data;
      end

      // Apply samples the shadow as it stood before this cycle's write.
      if (clken) begin
        if (apply) begin
          inc_act_d[c] = inc_sh_q[c];
          off_act_d[c] = off_sh_q[c];
        end
        acc_d[c]      = clr ? '0 : acc_q[c] + inc_act_q[c];
        phase_d[c]    = trunc_phase(acc_q[c], off_act_q[c]);
        sin_addr_d[c] = fold(quad_s[c], idx[c]);
        cos_addr_d[c] = fold(quad_c[c], idx[c]);
        sin_neg2_d[c] = quad_s[c][1];
        cos_neg2_d[c] = quad_c[c][1];
        sin_neg3_d[c] = sin_neg2_q[c];
        cos_neg3_d[c] = cos_neg2_q[c];
        sin_d[c]      = sin_neg3_q[c] ? -{1'b0, sin_mag[c]} : {1'b0, sin_mag[c]};
        cos_d[c]      = cos_neg3_q[c] ? -{1'b0, cos_mag[c]} : {1'b0, cos_mag[c]};
      end
    end

    if (clken) begin
      if (fill_q != 2'd3) fill_d  = fill_q + 2'd1;
      else                valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q     <= '0;
      valid_q    <= 1'b0;
      sin_neg2_q <= '0;
      cos_neg2_q <= '0;
      sin_neg3_q <= '0;
      cos_neg3_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        inc_sh_q[c]   <= '0;
        off_sh_q[c]   <= '0;
        inc_act_q[c]  <= '0;
        off_act_q[c]  <= '0;
        acc_q[c]      <= '0;
        phase_q[c]    <= '0;
        sin_addr_q[c] <= '0;
        cos_addr_q[c] <= '0;
        sin_q[c]      <= '0;
        cos_q[c]      <= '0;
      end
    end else begin
      fill_q     <= fill_d;
      valid_q    <= valid_d;
      sin_neg2_q <= sin_neg2_d;
      cos_neg2_q <= cos_neg2_d;
      sin_neg3_q <= sin_neg3_d;
      cos_neg3_q <= cos_neg3_d;
      for (int c = 0; c < N_CH; c++) begin
        inc_sh_q[c]   <= inc_sh_d[c];
        off_sh_q[c]   <= off_sh_d[c];
        inc_act_q[c]  <= inc_act_d[c];
        off_act_q[c]  <= off_act_d[c];
        acc_q[c]      <= acc_d[c];
        phase_q[c]    <= phase_d[c];
        sin_addr_q[c] <= sin_addr_d[c];
        cos_addr_q[c] <= cos_addr_d[c];
        sin_q[c]      <= sin_d[c];
        cos_q[c]      <= cos_d[c];
      end
    end
  end

  always_comb begin
    fsin_o = '0;
    fcos_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      fsin_o[c*OUT_W +: OUT_W] = sin_q[c];
      fcos_o[c*OUT_W +: OUT_W] = cos_q[c];
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_nco_multi_ch.sv
// Scoreboard bench for nco_multi_ch: a real-valued sine reference predicts
// every sample; a separate monitor pops and compares on each enabled edge.
module tb_nco_multi_ch;

  localparam int  N_CH   = 2;
  localparam int  ACC_W  = 32;
  localparam int  LUT_AW = 10;
  localparam int  OUT_W  = 14;
  localparam int  PH_W   = LUT_AW + 2;
  localparam real AMP    = real'((1 << (OUT_W - 1)) - 1);
  localparam real TB_PI  = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  clken;
  logic                  cfg_we;
  logic [0:0]            cfg_ch;
  logic                  cfg_sel;
  logic [ACC_W-1:0]      cfg_data;
  logic                  apply;
  logic                  clr;
  logic [N_CH*OUT_W-1:0] fsin_o;
  logic [N_CH*OUT_W-1:0] fcos_o;
  logic                  out_valid;

  nco_multi_ch #(.N_CH(N_CH), .ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .apply(apply), .clr(clr), .fsin_o(fsin_o), .fcos_o(fcos_o),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference state: what the channel registers hold after each enabled edge.
  logic [ACC_W-1:0] mAcc   [N_CH];
  logic [ACC_W-1:0] mInc   [N_CH];
  logic [ACC_W-1:0] mOff   [N_CH];
  logic [ACC_W-1:0] mIncSh [N_CH];
  logic [ACC_W-1:0] mOffSh [N_CH];
  int               mEdges;
  logic [N_CH*OUT_W-1:0] expSinQ[$];
  logic [N_CH*OUT_W-1:0] expCosQ[$];
  logic [N_CH*OUT_W-1:0] lastSin, lastCos;
  bit               haveLast;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int chVal(input logic [N_CH*OUT_W-1:0] v, input int c);
    logic signed [OUT_W-1:0] s;
    s = v[c*OUT_W +: OUT_W];
    return int'(s);
  endfunction

  // Ideal sample at a full-cycle phase index, using midpoint sampling.
  function automatic int refSample(input int unsigned p);
    real s;
    s = AMP * $sin(2.0 * TB_PI * (real'(p) + 0.5) / real'(1 << PH_W));
    if (s >= 0.0) return $rtoi(s + 0.5);
    return -$rtoi(0.5 - s);
  endfunction

  task automatic pushExpected();
    logic [N_CH*OUT_W-1:0] vs, vc;
    logic [ACC_W-1:0]      ph;
    int unsigned           p;
    vs = '0;
    vc = '0;
    for (int c = 0; c < N_CH; c++) begin
      ph = mAcc[c] + mOff[c];
      p  = int'(ph >> (ACC_W - PH_W));
      vs[c*OUT_W +: OUT_W] = OUT_W'(refSample(p));
      vc[c*OUT_W +: OUT_W] = OUT_W'(refSample((p + (1 << LUT_AW)) % (1 << PH_W)));
    end
    expSinQ.push_back(vs);
    expCosQ.push_back(vc);
  endtask

  task automatic resetModel();
    for (int c = 0; c < N_CH; c++) begin
      mAcc[c]   = '0;
      mInc[c]   = '0;
      mOff[c]   = '0;
      mIncSh[c] = '0;
      mOffSh[c] = '0;
    end
    mEdges   = 0;
    haveLast = 0;
    expSinQ.delete();
    expCosQ.delete();
    pushExpected();
  endtask

  // Drive one cycle's inputs at the falling edge and advance the reference.
  task automatic applyStimulus(input bit en, input bit we, input int ch, input bit sel,
                               input logic [ACC_W-1:0] data, input bit ap, input bit cl);
    @(negedge clk);
    clken    = en;
    cfg_we   = we;
    cfg_ch   = 1'(ch);
    cfg_sel  = sel;
    cfg_data = data;
    apply    = ap;
    clr      = cl;
    if (en) begin
      for (int c = 0; c < N_CH; c++) begin
        mAcc[c] = cl ? '0 : mAcc[c] + mInc[c];
        if (ap) begin
          mInc[c] = mIncSh[c];
          mOff[c] = mOffSh[c];
        end
      end
      mEdges++;
    end
    if (we && ch < N_CH) begin
      if (sel) mOffSh[ch] = data;
      else     mIncSh[ch] = data;
    end
    if (en) pushExpected();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic writeCfg(input int ch, input bit sel, input logic [ACC_W-1:0] data);
    applyStimulus(1'b1, 1'b1, ch, sel, data, 1'b0, 1'b0);
  endtask

  // Monitor: one expected sample per enabled edge once the pipeline is full.
  initial begin : monitor
    logic                  en, live;
    logic [N_CH*OUT_W-1:0] es, ec;
    forever begin
      @(posedge clk);
      en   = clken;
      live = reset_n;
      #1;
      if (live && reset_n) begin
        checkOutput("out_valid", int'(out_valid), int'(mEdges >= 4));
        if (mEdges >= 4 && en) begin
          if (expSinQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a sample");
          end else begin
            es = expSinQ.pop_front();
            ec = expCosQ.pop_front();
            for (int c = 0; c < N_CH; c++) begin
              checkOutput($sformatf("sin ch%0d t=%0t", c, $time), chVal(fsin_o, c), chVal(es, c));
              checkOutput($sformatf("cos ch%0d t=%0t", c, $time), chVal(fcos_o, c), chVal(ec, c));
            end
            lastSin  = es;
            lastCos  = ec;
            haveLast = 1;
          end
        end else if (mEdges >= 4 && haveLast) begin
          for (int c = 0; c < N_CH; c++) begin
            checkOutput($sformatf("hold sin ch%0d", c), chVal(fsin_o, c), chVal(lastSin, c));
            checkOutput($sformatf("hold cos ch%0d", c), chVal(fcos_o, c), chVal(lastCos, c));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin : stimulus
    reset_n  = 1'b0;
    clken    = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_sel  = 1'b0;
    cfg_data = '0;
    apply    = 1'b0;
    clr      = 1'b0;
    resetModel();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Pipeline fill with zero increment.
    idle(5);
    checkOutput("fill valid", int'(out_valid), 1);
    for (int c = 0; c < N_CH; c++) begin
      checkOutput($sformatf("fill sin ch%0d", c), chVal(fsin_o, c), 6);
      checkOutput($sformatf("fill cos ch%0d", c), chVal(fcos_o, c), 8191);
    end

    // Quarter-cycle step on channel 0.
    writeCfg(0, 1'b0, 32'h4000_0000);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b1, 1'b1);
    idle(12);

    // Half-cycle offset on channel 1.
    writeCfg(1, 1'b0, 32'h0000_0000);
    writeCfg(1, 1'b1, 32'h8000_0000);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    idle(6);
    checkOutput("offset sin ch1", chVal(fsin_o, 1), -6);
    checkOutput("offset cos ch1", chVal(fcos_o, 1), -8191);

    // Atomic retune: shadow writes alone change nothing until apply.
    writeCfg(0, 1'b0, 32'h0123_4567);
    writeCfg(1, 1'b0, 32'h0765_4321);
    idle(5);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    idle(8);

    // Stall: apply and clr while clken is low are dropped.
    writeCfg(0, 1'b0, 32'h2000_0000);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b1);
    idle(6);

    // Collision: same-cycle write and apply copies the older shadow.
    applyStimulus(1'b1, 1'b1, 0, 1'b0, 32'h1000_0000, 1'b1, 1'b0);
    idle(6);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    idle(6);

    // Wrap: decrement by one per sample from zero.
    writeCfg(0, 1'b0, 32'hFFFF_FFFF);
    writeCfg(0, 1'b1, 32'h0000_0000);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b1, 1'b1);
    idle(10);
    checkOutput("wrap sin ch0", chVal(fsin_o, 0), -6);
    checkOutput("wrap cos ch0", chVal(fcos_o, 0), 8191);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, N_CH - 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    idle(6);

    // Asynchronous reset mid-run.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset fsin", int'(fsin_o != '0), 0);
    checkOutput("reset fcos", int'(fcos_o != '0), 0);
    checkOutput("reset valid", int'(out_valid), 0);
    resetModel();
    clken = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    checkOutput("refill valid low", int'(out_valid), 0);
    writeCfg(1, 1'b0, 32'h0300_0000);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    idle(10);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
